// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter
//    Sequential CLIC priority arbiter. Scans SrcPerCycle sources per cycle,
//    keeps the best (highest level, lowest ID) eligible source over a full
//    pass, then presents it to the core through a valid/ready handshake.
//    An accepted interrupt produces a one-cycle claim pulse, and its ID is
//    hidden from the following pass while upstream clears the pending bit.
//
//    state   | meaning
//    --------+------------------------------------------------------------
//    SCAN    | walking chunks, merging the per-chunk best into best_*
//    PRESENT | irq_valid_o high, waiting for ready or withdrawal
//    CLAIM   | claim_valid_o pulse for the accepted ID, then rescan
//
// Ports
//    clk_i, rst_ni          clock, synchronous active-low reset
//    ip_i, ie_i, level_i    per-source pending, enable, level
//    threshold_i            effective threshold (strict greater-than)
//    irq_valid_o/id/level   presented interrupt
//    irq_ready_i            core accepts the presented interrupt
//    claim_valid_o/id       one-cycle claim of the accepted source
module clic_irq_arbiter #(
   parameter int unsigned NumSrc      = 256,
   parameter int unsigned SrcPerCycle = 16,
   parameter int unsigned LevelWidth  = 8,
   parameter int unsigned IdWidth     = $clog2(NumSrc)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumSrc-1:0]            ip_i,
   input  logic [NumSrc-1:0]            ie_i,
   input  logic [NumSrc*LevelWidth-1:0] level_i,
   input  logic [LevelWidth-1:0]        threshold_i,
   output logic                         irq_valid_o,
   output logic [IdWidth-1:0]           irq_id_o,
   output logic [LevelWidth-1:0]        irq_level_o,
   input  logic                         irq_ready_i,
   output logic                         claim_valid_o,
   output logic [IdWidth-1:0]           claim_id_o
);

   localparam int unsigned NumChunks = NumSrc / SrcPerCycle;
   localparam int unsigned CntWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

   typedef enum logic [1:0] {SCAN, PRESENT, CLAIM} state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  best_vld_q, best_vld_d;
   logic [IdWidth-1:0]    best_id_q, best_id_d;
   logic [LevelWidth-1:0] best_lvl_q, best_lvl_d;
   logic                  mask_q, mask_d;
   logic [IdWidth-1:0]    mask_id_q, mask_id_d;
   logic                  irq_valid_d;
   logic [IdWidth-1:0]    irq_id_d;
   logic [LevelWidth-1:0] irq_level_d;
   logic                  claim_valid_d;
   logic [IdWidth-1:0]    claim_id_d;

   logic                  ch_vld;
   logic [IdWidth-1:0]    ch_id;
   logic [LevelWidth-1:0] ch_lvl;
   logic [IdWidth-1:0]    src_id;
   logic [LevelWidth-1:0] src_lvl;
   logic                  src_el;
   logic                  base_vld;
   logic [IdWidth-1:0]    base_id;
   logic [LevelWidth-1:0] base_lvl;
   logic                  take;
   logic                  mrg_vld;
   logic [IdWidth-1:0]    mrg_id;
   logic [LevelWidth-1:0] mrg_lvl;
   logic                  pres_el;

   // Best of the current chunk; ascending scan with strict compare keeps
   // the lowest ID on equal levels.
   always_comb begin
      ch_vld  = 1'b0;
      ch_id   = '0;
      ch_lvl  = '0;
      src_id  = '0;
      src_lvl = '0;
      src_el  = 1'b0;
      for (int j = 0; j < int'(SrcPerCycle); j++) begin
         src_id  = IdWidth'(cnt_q) * IdWidth'(SrcPerCycle) + IdWidth'(j);
         src_lvl = level_i[src_id*LevelWidth +: LevelWidth];
         src_el  = ip_i[src_id] & ie_i[src_id] & (src_lvl > threshold_i)
                   & ~(mask_q & (mask_id_q == src_id));
         if (src_el && (!ch_vld || (src_lvl > ch_lvl))) begin
            ch_vld = 1'b1;
            ch_id  = src_id;
            ch_lvl = src_lvl;
         end
      end
   end

   // Chunk 0 always merges against an empty best, so a pass never inherits
   // a stale result.
   always_comb begin
      base_vld = (cnt_q == '0) ? 1'b0 : best_vld_q;
      base_id  = (cnt_q == '0) ? '0   : best_id_q;
      base_lvl = (cnt_q == '0) ? '0   : best_lvl_q;
      take     = ch_vld & (~base_vld | (ch_lvl > base_lvl));
      mrg_vld  = base_vld | ch_vld;
      mrg_id   = take ? ch_id  : base_id;
      mrg_lvl  = take ? ch_lvl : base_lvl;
   end

   assign pres_el = ip_i[irq_id_o] & ie_i[irq_id_o] & (irq_level_o > threshold_i);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      best_vld_d    = best_vld_q;
      best_id_d     = best_id_q;
      best_lvl_d    = best_lvl_q;
      mask_d        = mask_q;
      mask_id_d     = mask_id_q;
      irq_valid_d   = irq_valid_o;
      irq_id_d      = irq_id_o;
      irq_level_d   = irq_level_o;
      claim_valid_d = 1'b0;
      claim_id_d    = claim_id_o;
      case (state_q)
         SCAN: begin
            if (cnt_q == LastCnt) begin
               cnt_d      = '0;
               best_vld_d = 1'b0;
               best_id_d  = '0;
               best_lvl_d = '0;
               mask_d     = 1'b0;
               if (mrg_vld) begin
                  state_d     = PRESENT;
                  irq_valid_d = 1'b1;
                  irq_id_d    = mrg_id;
                  irq_level_d = mrg_lvl;
               end
            end else begin
               cnt_d      = cnt_q + 1'b1;
               best_vld_d = mrg_vld;
               best_id_d  = mrg_id;
               best_lvl_d = mrg_lvl;
            end
         end
         PRESENT: begin
            // Acceptance wins over a simultaneous loss of eligibility.
            if (irq_ready_i) begin
               state_d       = CLAIM;
               irq_valid_d   = 1'b0;
               claim_valid_d = 1'b1;
               claim_id_d    = irq_id_o;
               mask_d        = 1'b1;
               mask_id_d     = irq_id_o;
            end else if (!pres_el) begin
               state_d     = SCAN;
               irq_valid_d = 1'b0;
               cnt_d       = '0;
               best_vld_d  = 1'b0;
               best_id_d   = '0;
               best_lvl_d  = '0;
            end
         end
         CLAIM: begin
            state_d    = SCAN;
            cnt_d      = '0;
            best_vld_d = 1'b0;
            best_id_d  = '0;
            best_lvl_d = '0;
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= SCAN;
         cnt_q         <= '0;
         best_vld_q    <= 1'b0;
         best_id_q     <= '0;
         best_lvl_q    <= '0;
         mask_q        <= 1'b0;
         mask_id_q     <= '0;
         irq_valid_o   <= 1'b0;
         irq_id_o      <= '0;
         irq_level_o   <= '0;
         claim_valid_o <= 1'b0;
         claim_id_o    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         best_vld_q    <= best_vld_d;
         best_id_q     <= best_id_d;
         best_lvl_q    <= best_lvl_d;
         mask_q        <= mask_d;
         mask_id_q     <= mask_id_d;
         irq_valid_o   <= irq_valid_d;
         irq_id_o      <= irq_id_d;
         irq_level_o   <= irq_level_d;
         claim_valid_o <= claim_valid_d;
         claim_id_o    <= claim_id_d;
      end
   end

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb_clic_irq_arbiter
//    Self-checking bench for clic_irq_arbiter at default parameters.
//    Expected presentations are queued as sources are raised and popped
//    when irq_valid_o is seen.
module tb_clic_irq_arbiter;

   localparam int NumSrc = 256;
   localparam int LW     = 8;

   logic                 clk;
   logic                 rst_n;
   logic [NumSrc-1:0]    ip;
   logic [NumSrc-1:0]    ie;
   logic [NumSrc*LW-1:0] level;
   logic [LW-1:0]        thr;
   logic                 ready;
   logic                 irq_valid;
   logic [7:0]           irq_id;
   logic [LW-1:0]        irq_level;
   logic                 claim_valid;
   logic [7:0]           claim_id;

   typedef struct {
      int id;
      int lvl;
   } exp_t;

   exp_t sb[$];
   int   n_checks;
   int   n_errors;
   int   cur_id;
   int   n;
   int   cnt_v;
   int   cnt_c;

   clic_irq_arbiter dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .ip_i          (ip),
      .ie_i          (ie),
      .level_i       (level),
      .threshold_i   (thr),
      .irq_valid_o   (irq_valid),
      .irq_id_o      (irq_id),
      .irq_level_o   (irq_level),
      .irq_ready_i   (ready),
      .claim_valid_o (claim_valid),
      .claim_id_o    (claim_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input int id, input int lvl);
      level[id*LW +: LW] = LW'(lvl);
      ip[id] = 1'b1;
   endtask

   task automatic expect_irq(input int id, input int lvl);
      exp_t e;
      e.id  = id;
      e.lvl = lvl;
      sb.push_back(e);
   endtask

   // Waits for irq_valid_o within budget cycles, then compares against the
   // oldest queued expectation.
   task automatic wait_present(input string tag, input int budget, output int cycles);
      exp_t e;
      cycles = 0;
      while (!irq_valid && cycles < budget) begin
         tick();
         cycles++;
      end
      check({tag, "_valid"}, int'(irq_valid), 1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         cur_id = e.id;
         if (irq_valid) begin
            check({tag, "_id"}, int'(irq_id), e.id);
            check({tag, "_lvl"}, int'(irq_level), e.lvl);
         end
      end
   endtask

   task automatic do_claim(input string tag);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check({tag, "_claim_v"}, int'(claim_valid), 1);
      check({tag, "_claim_id"}, int'(claim_id), cur_id);
      check({tag, "_valid_off"}, int'(irq_valid), 0);
      tick();
      check({tag, "_claim_pulse"}, int'(claim_valid), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, int'(irq_valid), 0);
      check({tag, "_id"}, int'(irq_id), 0);
      check({tag, "_lvl"}, int'(irq_level), 0);
      check({tag, "_cvalid"}, int'(claim_valid), 0);
      check({tag, "_cid"}, int'(claim_id), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      cur_id   = 0;
      rst_n    = 1'b0;
      ip       = '0;
      ie       = '1;
      level    = '0;
      thr      = '0;
      ready    = 1'b0;
      repeat (2) tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // single source
      raise(37, 5);
      expect_irq(37, 5);
      wait_present("single", 32, n);
      do_claim("single");
      ip[37] = 1'b0;

      // ties across chunks resolve to the lowest ID
      raise(3, 9);
      raise(200, 9);
      raise(17, 9);
      expect_irq(3, 9);
      wait_present("tie", 40, n);
      level[200*LW +: LW] = 8'd10;
      repeat (20) tick();
      check("no_preempt_valid", int'(irq_valid), 1);
      check("no_preempt_id", int'(irq_id), 3);
      do_claim("tie");
      ip[3] = 1'b0;
      expect_irq(200, 10);
      wait_present("raised", 40, n);
      do_claim("raised");
      ip[200] = 1'b0;
      expect_irq(17, 9);
      wait_present("left", 40, n);
      do_claim("left");
      ip[17] = 1'b0;

      // threshold is a strict compare
      thr = 8'd4;
      raise(50, 4);
      cnt_v = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (irq_valid) cnt_v++;
      end
      check("thr_equal_blocks", cnt_v, 0);
      thr = 8'd3;
      expect_irq(50, 4);
      wait_present("thr_lowered", 33, n);
      do_claim("thr");
      ip[50] = 1'b0;
      thr = 8'd0;

      // withdrawal while ready is low
      repeat (20) tick();
      raise(10, 7);
      expect_irq(10, 7);
      wait_present("wd", 40, n);
      ip[10] = 1'b0;
      tick();
      check("wd_drop", int'(irq_valid), 0);
      cnt_v = 0;
      cnt_c = 0;
      for (int i = 0; i < 40; i++) begin
         if (irq_valid) cnt_v++;
         if (claim_valid) cnt_c++;
         tick();
      end
      check("wd_no_claim", cnt_c, 0);
      check("wd_no_valid", cnt_v, 0);

      // claim mask: level source 0 stays pending after claim
      raise(0, 3);
      expect_irq(0, 3);
      wait_present("mask_first", 40, n);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("mask_claim_v", int'(claim_valid), 1);
      check("mask_claim_id", int'(claim_id), 0);
      expect_irq(0, 3);
      wait_present("mask_again", 60, n);
      check("mask_claim_to_valid", n, 33);
      do_claim("mask");
      ip[0] = 1'b0;

      // reset while presenting
      repeat (20) tick();
      raise(90, 2);
      expect_irq(90, 2);
      wait_present("rst_pre", 40, n);
      rst_n = 1'b0;
      tick();
      check_outputs_zero("rst_mid");
      rst_n = 1'b1;
      expect_irq(90, 2);
      wait_present("rst_post", 40, n);
      check("rst_rescan_cycles", n, 16);
      do_claim("rst");
      ip[90] = 1'b0;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
